// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus_uart peripheral: register offsets,
// STAT/CTRL bit positions and the common RX/TX state encoding.
package bus_uart_pkg;

    localparam logic [1:0] ADDR_RXTX    = 2'd0;
    localparam logic [1:0] ADDR_DIVISOR = 2'd1;
    localparam logic [1:0] ADDR_STAT    = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    localparam int STAT_RX_DONE = 0;
    localparam int STAT_TX_DONE = 1;
    localparam int STAT_TX_BUSY = 2;
    localparam int STAT_RX_OVR  = 3;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Tick counts: mid-start sample after 8 ticks, a full bit is 16 ticks.
    localparam logic [3:0] TICKS_HALF = 4'd7;
    localparam logic [3:0] TICKS_FULL = 4'd15;

endpackage

// File: rtl/bus_uart_baud_gen.sv
// 16x oversampling tick generator: one-cycle pulse every divisor+1 clocks,
// restarted from the newly written value whenever the divisor is written.
module uart_baud_gen #(
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd27
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [15:0] i_divisor,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    output logic        o_tick
);

    logic [15:0] r_cnt;
    logic        r_tick;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt  <= DEFAULT_DIVISOR;
            r_tick <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= i_load_val;
            r_tick <= 1'b0;
        end else if (r_cnt == 16'd0) begin
            r_cnt  <= i_divisor;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt - 16'd1;
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART with programmable baud divisor, 16x oversampled
// receiver and level interrupts for receive- and transmit-complete.
module bus_uart
    import bus_uart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd27
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] dat_i,
    input  logic [31:0] adr_i,
    input  logic        we_i,
    input  logic        stb_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        rx_irq,
    output logic        tx_irq,
    input  logic        uart_rx,
    output logic        uart_tx
);

    logic [15:0] r_div;
    logic        r_rx_ie, r_tx_ie;
    logic        r_rx_done, r_tx_done, r_rx_ovr;
    logic [7:0]  r_rx_data;
    logic        r_ack;
    logic [31:0] r_dat_o;
    logic        r_rx_irq, r_tx_irq;

    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    logic [1:0]  r_rx_state;
    logic [3:0]  r_rx_tcnt;
    logic [2:0]  r_rx_bcnt;
    logic [7:0]  r_rx_shift;

    logic [1:0]  r_tx_state;
    logic [3:0]  r_tx_tcnt;
    logic [2:0]  r_tx_bcnt;
    logic [7:0]  r_tx_shift;
    logic        r_tx;

    logic        w_tick;
    logic        w_acc, w_wr, w_rd;
    logic [1:0]  w_addr;
    logic        w_div_wr, w_stat_wr, w_ctrl_wr, w_rx_rd, w_tx_start;
    logic        w_rx_good, w_tx_end, w_tx_busy;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_unused = ^{adr_i[31:4], adr_i[1:0], dat_i[31:16]};

    // A held strobe is served every second cycle because ack blocks the next access.
    assign w_acc      = stb_i & ~r_ack;
    assign w_wr       = w_acc & we_i;
    assign w_rd       = w_acc & ~we_i;
    assign w_addr     = adr_i[3:2];
    assign w_div_wr   = w_wr && (w_addr == ADDR_DIVISOR);
    assign w_stat_wr  = w_wr && (w_addr == ADDR_STAT);
    assign w_ctrl_wr  = w_wr && (w_addr == ADDR_CTRL);
    assign w_rx_rd    = w_rd && (w_addr == ADDR_RXTX);
    assign w_tx_busy  = (r_tx_state != ST_IDLE);
    assign w_tx_start = w_wr && (w_addr == ADDR_RXTX) && !w_tx_busy;

    assign w_rx_good = (r_rx_state == ST_STOP) && w_tick && (r_rx_tcnt == TICKS_FULL) && r_rx_s2;
    assign w_tx_end  = (r_tx_state == ST_STOP) && w_tick && (r_tx_tcnt == TICKS_FULL);

    uart_baud_gen #(
        .DEFAULT_DIVISOR(DEFAULT_DIVISOR)
    ) u_baud (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .i_divisor (r_div),
        .i_load    (w_div_wr),
        .i_load_val(dat_i[15:0]),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            ADDR_RXTX:    w_rdata = {24'b0, r_rx_data};
            ADDR_DIVISOR: w_rdata = {16'b0, r_div};
            ADDR_STAT:    w_rdata = {28'b0, r_rx_ovr, w_tx_busy, r_tx_done, r_rx_done};
            ADDR_CTRL:    w_rdata = {30'b0, r_tx_ie, r_rx_ie};
            default:      ;
        endcase
    end

    // Hardware flag sets take priority over bus clears in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_div     <= DEFAULT_DIVISOR;
            r_rx_ie   <= 1'b0;
            r_tx_ie   <= 1'b0;
            r_rx_done <= 1'b0;
            r_tx_done <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_ack     <= 1'b0;
            r_dat_o   <= '0;
            r_rx_irq  <= 1'b0;
            r_tx_irq  <= 1'b0;
        end else begin
            if (w_div_wr)
                r_div <= dat_i[15:0];
            if (w_ctrl_wr) begin
                r_rx_ie <= dat_i[CTRL_RX_IE];
                r_tx_ie <= dat_i[CTRL_TX_IE];
            end
            if (w_rx_good)
                r_rx_done <= 1'b1;
            else if (w_rx_rd || (w_stat_wr && dat_i[STAT_RX_DONE]))
                r_rx_done <= 1'b0;
            if (w_rx_good && r_rx_done)
                r_rx_ovr <= 1'b1;
            else if (w_stat_wr && dat_i[STAT_RX_OVR])
                r_rx_ovr <= 1'b0;
            if (w_tx_end)
                r_tx_done <= 1'b1;
            else if (w_tx_start || (w_stat_wr && dat_i[STAT_TX_DONE]))
                r_tx_done <= 1'b0;
            r_ack    <= w_acc;
            r_dat_o  <= w_rd ? w_rdata : 32'd0;
            r_rx_irq <= r_rx_done & r_rx_ie;
            r_tx_irq <= r_tx_done & r_tx_ie;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_tcnt  <= 4'd0;
            r_rx_bcnt  <= 3'd0;
        end else begin
            r_rx_s1   <= uart_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            case (r_rx_state)
                ST_IDLE: begin
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_state <= ST_START;
                        r_rx_tcnt  <= 4'd0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == TICKS_HALF) begin
                            r_rx_tcnt  <= 4'd0;
                            r_rx_bcnt  <= 3'd0;
                            r_rx_state <= r_rx_s2 ? ST_IDLE : ST_DATA;
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == TICKS_FULL) begin
                            r_rx_tcnt <= 4'd0;
                            r_rx_bcnt <= r_rx_bcnt + 3'd1;
                            if (r_rx_bcnt == 3'd7)
                                r_rx_state <= ST_STOP;
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == TICKS_FULL)
                            r_rx_state <= ST_IDLE;
                        else
                            r_rx_tcnt <= r_rx_tcnt + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if ((r_rx_state == ST_DATA) && w_tick && (r_rx_tcnt == TICKS_FULL))
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        if (w_rx_good)
            r_rx_data <= r_rx_shift;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_tcnt  <= 4'd0;
            r_tx_bcnt  <= 3'd0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    if (w_tx_start) begin
                        r_tx_state <= ST_START;
                        r_tx_tcnt  <= 4'd0;
                        r_tx       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_tx_tcnt == TICKS_FULL) begin
                            r_tx_state <= ST_DATA;
                            r_tx_tcnt  <= 4'd0;
                            r_tx_bcnt  <= 3'd0;
                            r_tx       <= r_tx_shift[0];
                        end else begin
                            r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_tx_tcnt == TICKS_FULL) begin
                            r_tx_tcnt <= 4'd0;
                            r_tx_bcnt <= r_tx_bcnt + 3'd1;
                            if (r_tx_bcnt == 3'd7) begin
                                r_tx_state <= ST_STOP;
                                r_tx       <= 1'b1;
                            end else begin
                                r_tx <= r_tx_shift[1];
                            end
                        end else begin
                            r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_tx_tcnt == TICKS_FULL)
                            r_tx_state <= ST_IDLE;
                        else
                            r_tx_tcnt <= r_tx_tcnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // The bit on the line is shift[0]; the next one is read from shift[1] before shifting.
    always_ff @(posedge sys_clk) begin
        if (w_tx_start)
            r_tx_shift <= dat_i[7:0];
        else if ((r_tx_state == ST_DATA) && w_tick && (r_tx_tcnt == TICKS_FULL))
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
    end

    assign dat_o   = r_dat_o;
    assign ack_o   = r_ack;
    assign rx_irq  = r_rx_irq;
    assign tx_irq  = r_tx_irq;
    assign uart_tx = r_tx;

endmodule

// File: tb/tb_bus_uart.sv
// Directed bench for bus_uart: bus handshake, register reset values,
// glitch rejection, reception, framing error, transmission and overrun.
`timescale 1ns/1ps
module tb_bus_uart;
    import bus_uart_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] dat_i, adr_i;
    logic        we_i, stb_i;
    logic [31:0] dat_o;
    logic        ack_o, rx_irq, tx_irq;
    logic        uart_rx, uart_tx;

    int n_chk = 0;
    int n_bad = 0;

    bus_uart dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .dat_i(dat_i), .adr_i(adr_i), .we_i(we_i), .stb_i(stb_i),
        .dat_o(dat_o), .ack_o(ack_o),
        .rx_irq(rx_irq), .tx_irq(tx_irq),
        .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic [1:0] a, input logic wr, input logic [31:0] wd,
                       output logic [31:0] rd);
        @(posedge sys_clk); #1;
        stb_i = 1'b1; we_i = wr; adr_i = {28'b0, a, 2'b00}; dat_i = wd;
        @(posedge sys_clk); #1;
        chk("ack", {31'b0, ack_o}, 32'd1);
        rd = dat_o;
        stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] x;
        bus(a, 1'b1, d, x);
    endtask

    task automatic reg_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] x;
        bus(a, 1'b0, 32'd0, x);
        chk(tag, x, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        #320;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #320;
        end
        uart_rx = stop;
        #320;
        uart_rx = 1'b1;
    endtask

    task automatic wait_until(input time t);
        if (t > $time) #(t - $time);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        time t0;
        sys_rst = 1'b1; stb_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0; uart_rx = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_rx_irq", {31'b0, rx_irq}, 32'd0);
        chk("rst_tx_irq", {31'b0, tx_irq}, 32'd0);
        chk("rst_ack", {31'b0, ack_o}, 32'd0);
        chk("rst_dat_o", dat_o, 32'd0);
        reg_rd("rst_stat", ADDR_STAT, 32'd0);
        reg_rd("rst_ctrl", ADDR_CTRL, 32'd0);
        reg_rd("rst_div", ADDR_DIVISOR, 32'd27);

        // Held strobe: ack and data every second cycle, zero data in between.
        @(posedge sys_clk); #1;
        stb_i = 1'b1; we_i = 1'b0; adr_i = {28'b0, ADDR_DIVISOR, 2'b00};
        for (int i = 0; i < 4; i++) begin
            @(posedge sys_clk); #1;
            chk("held_ack", {31'b0, ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("held_dat", dat_o, (i % 2 == 0) ? 32'd27 : 32'd0);
        end
        stb_i = 1'b0;

        // Short low pulses at the default divisor are rejected as glitches.
        reg_wr(ADDR_CTRL, 32'd1);
        for (int i = 0; i < 4; i++) begin
            uart_rx = 1'b0;
            #400;
            uart_rx = 1'b1;
            #3000;
        end
        #3000;
        chk("glitch_rx_irq", {31'b0, rx_irq}, 32'd0);
        reg_rd("glitch_stat", ADDR_STAT, 32'd0);

        // Receive 0xA5 at 320 ns/bit.
        reg_wr(ADDR_DIVISOR, 32'd0);
        reg_wr(ADDR_CTRL, 32'd1);
        reg_rd("div_zero", ADDR_DIVISOR, 32'd0);
        send_frame(8'hA5, 1'b1);
        #100;
        chk("rx_irq_set", {31'b0, rx_irq}, 32'd1);
        reg_rd("rx_stat", ADDR_STAT, 32'd1);
        reg_rd("rx_data", ADDR_RXTX, 32'h0000_00A5);
        @(posedge sys_clk); #1;
        chk("rx_irq_clr", {31'b0, rx_irq}, 32'd0);
        reg_rd("rx_stat_clr", ADDR_STAT, 32'd0);

        // Framing error: stop bit low discards the byte.
        send_frame(8'hA5, 1'b0);
        #400;
        reg_rd("frame_err_stat", ADDR_STAT, 32'd0);
        chk("frame_err_irq", {31'b0, rx_irq}, 32'd0);

        // Transmit 0xFF; a second write during the frame must be ignored.
        reg_wr(ADDR_CTRL, 32'd2);
        reg_wr(ADDR_RXTX, 32'h0000_00FF);
        t0 = $time - 1;
        chk("tx_start_edge", {31'b0, uart_tx}, 32'd0);
        reg_rd("tx_busy_stat", ADDR_STAT, 32'd4);
        reg_wr(ADDR_RXTX, 32'h0000_0000);
        wait_until(t0 + 160);
        chk("tx_start_mid", {31'b0, uart_tx}, 32'd0);
        for (int k = 0; k < 9; k++) begin
            wait_until(t0 + 320 * (k + 1) + 160);
            chk("tx_bit", {31'b0, uart_tx}, 32'd1);
        end
        chk("tx_irq_early", {31'b0, tx_irq}, 32'd0);
        wait_until(t0 + 3260);
        chk("tx_irq_set", {31'b0, tx_irq}, 32'd1);
        chk("tx_idle", {31'b0, uart_tx}, 32'd1);
        reg_rd("tx_done_stat", ADDR_STAT, 32'd2);
        reg_wr(ADDR_STAT, 32'd2);
        @(posedge sys_clk); #1;
        chk("tx_irq_clr", {31'b0, tx_irq}, 32'd0);

        // Back-to-back frames without a read raise overrun.
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
        #100;
        reg_rd("ovr_stat", ADDR_STAT, 32'd9);
        reg_rd("ovr_data", ADDR_RXTX, 32'h0000_0081);
        reg_wr(ADDR_STAT, 32'd8);
        reg_rd("ovr_clr_stat", ADDR_STAT, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
